// File: rtl/mio_bridge.sv
// mio_bridge: bridges the multi-cycle CPU's memory/IO strobes onto block RAM,
// a GPIO block (LED register and switch inputs) and a free-running 32-bit timer.
// Each accepted access completes with a single-cycle MIO_ready pulse. Load data
// is returned on Data_in and held there until the next read captures new data.
module mio_bridge #(
    parameter int RAM_AW   = 10,  // RAM word-address width
    parameter int RAM_WAIT = 1,   // RAM wait cycles after accept, 1..15
    parameter int IO_W     = 16   // LED / switch width, at most 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [IO_W-1:0]   sw_in,
    output logic [IO_W-1:0]   led_out,
    output logic [1:0]        bus_state
);

    // Encodings double as the debug value on bus_state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_GPIO,
        RGN_TIMER,
        RGN_NONE
    } region_t;

    // The wait counter runs from RAM_WAIT-1 down to 0; zero marks the last WAIT cycle.
    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);

    state_t             state_reg, state_next;
    logic [3:0]         wait_cnt_reg, wait_cnt_next;
    region_t            region;
    logic               accept;
    logic               accept_ram;
    logic               led_sel;
    logic               sw_sel;
    logic               last_wait;
    logic [31:0]        io_rdata;
    logic [RAM_AW-1:0]  word_addr;

    logic [RAM_AW-1:0]  ram_addr_reg;
    logic [31:0]        ram_din_reg;
    logic               ram_we_reg;
    logic               ram_rd_reg;
    logic [31:0]        data_in_reg;
    logic [IO_W-1:0]    led_reg;
    logic [31:0]        timer_reg;

    // Byte-lane bits are irrelevant: every access is a full word.
    logic               unused_byte_lane;
    assign unused_byte_lane = &{1'b0, addr_bus[1:0]};

    // Address decode of the live bus; it only matters in the accept cycle.
    always_comb begin
        region = RGN_NONE;
        case (addr_bus[31:28])
            4'h0:    region = RGN_RAM;
            4'hE:    region = RGN_GPIO;
            4'hF:    region = RGN_TIMER;
            default: region = RGN_NONE;
        endcase
    end

    assign word_addr  = addr_bus[RAM_AW+1:2];
    assign led_sel    = (addr_bus[27:2] == 26'd0);
    assign sw_sel     = (addr_bus[27:2] == 26'd1);
    assign accept     = (state_reg == ST_IDLE) && CPU_MIO && (MemRead || MemWrite);
    assign accept_ram = accept && (region == RGN_RAM);
    assign last_wait  = (state_reg == ST_WAIT) && (wait_cnt_reg == 4'd0);

    // Read data for the single-cycle targets; unmapped addresses and
    // unmapped GPIO offsets read as zero.
    always_comb begin
        io_rdata = 32'd0;
        case (region)
            RGN_GPIO: begin
                if (led_sel) begin
                    io_rdata = 32'(led_reg);
                end else if (sw_sel) begin
                    io_rdata = 32'(sw_in);
                end
            end
            RGN_TIMER: io_rdata = timer_reg;
            default:   io_rdata = 32'd0;
        endcase
    end

    // Bus FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state logic: RAM goes through WAIT, everything else goes straight
    // to RESP. RESP always returns to IDLE, so a held request is re-accepted
    // no earlier than the cycle after the response.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (region == RGN_RAM) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // RAM request registers: address/data latched on accept, write strobe
    // high for only the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_reg <= '0;
            ram_din_reg  <= 32'd0;
            ram_we_reg   <= 1'b0;
            ram_rd_reg   <= 1'b0;
        end else begin
            ram_we_reg <= accept_ram && MemWrite;
            if (accept_ram) begin
                ram_addr_reg <= word_addr;
                ram_din_reg  <= Data_out;
                ram_rd_reg   <= !MemWrite;
            end
        end
    end

    // Load data register: single-cycle targets capture on the accept edge,
    // RAM reads capture on the last WAIT edge. Writes leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_in_reg <= 32'd0;
        end else if (accept && (region != RGN_RAM) && !MemWrite) begin
            data_in_reg <= io_rdata;
        end else if (last_wait && ram_rd_reg) begin
            data_in_reg <= ram_dout;
        end
    end

    // LED register; writes to the switch offset or other offsets are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg <= '0;
        end else if (accept && (region == RGN_GPIO) && MemWrite && led_sel) begin
            led_reg <= Data_out[IO_W-1:0];
        end
    end

    // Free-running timer; a CPU write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= 32'd0;
        end else if (accept && (region == RGN_TIMER) && MemWrite) begin
            timer_reg <= Data_out;
        end else begin
            timer_reg <= timer_reg + 32'd1;
        end
    end

    // The RAM sees the incoming word address during the accept cycle so its
    // registered read is already valid in the first WAIT cycle; RAM_WAIT=1
    // therefore covers the one-cycle read latency.
    assign ram_addr  = accept_ram ? word_addr : ram_addr_reg;
    assign ram_din   = ram_din_reg;
    assign ram_we    = ram_we_reg;
    assign Data_in   = data_in_reg;
    assign led_out   = led_reg;
    assign MIO_ready = (state_reg == ST_RESP);
    assign bus_state = state_reg;

endmodule

// File: tb/tb_mio_bridge.sv
// tb_mio_bridge: randomized and directed accesses through mio_bridge. The driver
// predicts each response from the address-map rules and queues it; a monitor on
// the falling edge pops and compares whenever MIO_ready or ram_we shows up.
`timescale 1ns/1ps
module tb_mio_bridge;

    localparam int AW  = 10;
    localparam int IOW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT, RAM_WAIT = 1 ----------------
    logic            reset, cpu_mio, mem_read, mem_write;
    logic [31:0]     addr_bus, data_out, data_in, ram_din, ram_dout;
    logic            mio_ready, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [IOW-1:0]  sw_in, led_out;
    logic [1:0]      bus_state;

    mio_bridge #(.RAM_AW(AW), .RAM_WAIT(1), .IO_W(IOW)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(cpu_mio), .MemRead(mem_read),
        .MemWrite(mem_write), .addr_bus(addr_bus), .Data_out(data_out),
        .Data_in(data_in), .MIO_ready(mio_ready), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .sw_in(sw_in), .led_out(led_out), .bus_state(bus_state)
    );

    logic [31:0] mem1 [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem1[ram_addr] <= ram_din;
        ram_dout <= mem1[ram_addr];
    end

    // ---------------- second DUT, RAM_WAIT = 4 ----------------
    logic            reset4, cpu4, rd4, wr4;
    logic [31:0]     a4, d4, din4, ram_din4, ram_dout4;
    logic            rdy4, ram_we4;
    logic [AW-1:0]   ram_addr4;
    logic [IOW-1:0]  sw4, led4;
    logic [1:0]      state4;

    mio_bridge #(.RAM_AW(AW), .RAM_WAIT(4), .IO_W(IOW)) dut4 (
        .clk(clk), .reset(reset4), .CPU_MIO(cpu4), .MemRead(rd4),
        .MemWrite(wr4), .addr_bus(a4), .Data_out(d4),
        .Data_in(din4), .MIO_ready(rdy4), .ram_addr(ram_addr4),
        .ram_we(ram_we4), .ram_din(ram_din4), .ram_dout(ram_dout4),
        .sw_in(sw4), .led_out(led4), .bus_state(state4)
    );

    logic [31:0] mem4 [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we4) mem4[ram_addr4] <= ram_din4;
        ram_dout4 <= mem4[ram_addr4];
    end

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int            due;
        logic [31:0]   data;
        logic [IOW-1:0] led;
    } exp_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wexp_t;

    exp_t  sb[$];
    wexp_t wq[$];

    // Reference model: plain memory contents, LED value, last load value and
    // the timer as (value loaded, edge at which it was loaded).
    logic [31:0]    ram_ref [int];
    logic [IOW-1:0] led_ref;
    logic [31:0]    last_rd;
    logic [31:0]    t_base;
    int             t_edge;

    // Monitor: compares every response and RAM write strobe against the queues.
    always @(negedge clk) begin
        exp_t  e;
        wexp_t w;
        if (!reset) begin
            if (mio_ready) begin
                if (sb.size() == 0) begin
                    chk("ready_unexpected", 32'(mio_ready), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(e.due));
                    chk("data_in", data_in, e.data);
                    chk("led_out", 32'(led_out), 32'(e.led));
                    $display("txn done cyc=%0d data_in=0x%08h led=0x%04h", cyc, data_in, led_out);
                end
            end
            if (ram_we) begin
                if (wq.size() == 0) begin
                    chk("ram_we_unexpected", 32'(ram_we), 32'd0);
                end else begin
                    w = wq.pop_front();
                    chk("ram_we_cycle", 32'(cyc), 32'(w.due));
                    chk("ram_addr", 32'(ram_addr), 32'(w.a));
                    chk("ram_din", ram_din, w.d);
                end
            end
        end
    end

    // Predict one access from the address map; acc is the accept edge index.
    task automatic predict(input logic wr, input logic [31:0] a, input logic [31:0] d, input int acc);
        exp_t        e;
        wexp_t       w;
        logic [31:0] rv;
        logic [27:0] off;
        int          idx;
        off = {a[27:2], 2'b00};
        idx = int'(a[AW+1:2]);
        rv  = last_rd;
        e.due = acc;
        case (a[31:28])
            4'h0: begin
                e.due = acc + 1;
                if (wr) begin
                    ram_ref[idx] = d;
                    w.due = acc; w.a = a[AW+1:2]; w.d = d;
                    wq.push_back(w);
                end else begin
                    rv = ram_ref.exists(idx) ? ram_ref[idx] : 32'd0;
                end
            end
            4'hE: begin
                if (wr) begin
                    if (off == 28'd0) led_ref = d[IOW-1:0];
                end else if (off == 28'd0) rv = 32'(led_ref);
                else if (off == 28'd4) rv = 32'(sw_in);
                else rv = 32'd0;
            end
            4'hF: begin
                if (wr) begin
                    t_base = d;
                    t_edge = acc;
                end else begin
                    rv = t_base + 32'(acc - 1 - t_edge);
                end
            end
            default: if (!wr) rv = 32'd0;
        endcase
        last_rd = rv;
        e.data  = rv;
        e.led   = led_ref;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || wq.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || wq.size() != 0) begin
            chk("drain_timeout", 32'(sb.size() + wq.size()), 32'd0);
            sb.delete();
            wq.delete();
        end
    endtask

    task automatic bus_idle();
        cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr_bus = $urandom; data_out = $urandom;
    endtask

    // Called #1 after an edge with the DUT idle: the next edge accepts.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int idle);
        cpu_mio = 1'b1; mem_read = rd; mem_write = wr; addr_bus = a; data_out = d;
        predict(wr, a, d, cyc + 1);
        @(posedge clk); #1;
        bus_idle();
        wait_drain();
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin @(posedge clk); #1; end
    endtask

    // One access on the RAM_WAIT=4 instance, observed for 12 cycles.
    task automatic access4(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output int acc, output int rdy_cyc, output int we_cyc, output int we_cnt);
        acc = cyc + 1; rdy_cyc = -1; we_cyc = -1; we_cnt = 0;
        cpu4 = 1'b1; rd4 = !wr; wr4 = wr; a4 = a; d4 = d;
        @(posedge clk); #1;
        cpu4 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rdy4 && rdy_cyc < 0) rdy_cyc = cyc;
            if (ram_we4) begin we_cnt++; we_cyc = cyc; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, acc, rc, wc, wn, pulses, r, rw;
        logic [31:0] a;
        logic rd, wr;

        for (int i = 0; i < (1 << AW); i++) begin mem1[i] = 32'd0; mem4[i] = 32'd0; end
        reset = 1'b1; reset4 = 1'b1;
        bus_idle(); sw_in = '0;
        cpu4 = 1'b0; rd4 = 1'b0; wr4 = 1'b0; a4 = '0; d4 = '0; sw4 = 16'h0F0F;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mio_ready", 32'(mio_ready), 32'd0);
        chk("rst_led_out", 32'(led_out), 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_bus_state", 32'(bus_state), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        reset = 1'b0; reset4 = 1'b0;
        led_ref = '0; last_rd = 32'd0; t_base = 32'd0; t_edge = cyc;

        // 2: RAM write then read
        issue(1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 0);
        issue(1'b1, 1'b0, 32'h0000_0014, 32'h0, 0);

        // 3: LED write, switch read
        issue(1'b0, 1'b1, 32'hE000_0000, 32'h0000_A5A5, 0);
        sw_in = 16'h1234;
        issue(1'b1, 1'b0, 32'hE000_0004, 32'h0, 0);

        // 4: timer wrap, unmapped read
        issue(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 1);
        issue(1'b1, 1'b0, 32'hF000_0000, 32'h0, 0);
        issue(1'b1, 1'b0, 32'h7000_0000, 32'h0, 0);

        // 5: read+write together to RAM 0, request held across the response
        k = cyc;
        cpu_mio = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
        addr_bus = 32'h0; data_out = 32'hCAFE_F00D;
        predict(1'b1, 32'h0, 32'hCAFE_F00D, k + 1);
        predict(1'b1, 32'h0, 32'hCAFE_F00D, k + 4);
        wait_cyc(k + 4);
        bus_idle();
        wait_drain();
        issue(1'b1, 1'b0, 32'h0000_0000, 32'h0, 0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            r  = int'($urandom_range(0, 9));
            rw = int'($urandom_range(0, 3));
            wr = (rw == 1 || rw == 2);
            rd = (rw != 1);
            a  = $urandom;
            if (r < 4) begin
                a[31:28] = 4'h0;
                a[11:6]  = 6'd0;
            end else if (r < 6) begin
                a[31:28] = 4'hE;
                case ($urandom_range(0, 3))
                    0: a[27:2] = 26'd0;
                    1: a[27:2] = 26'd1;
                    2: a[27:2] = 26'd2;
                    default: ;
                endcase
            end else if (r < 8) begin
                a[31:28] = 4'hF;
            end else begin
                a[31:28] = 4'($urandom_range(1, 13));
            end
            sw_in = 16'($urandom);
            issue(rd, wr, a, $urandom, int'($urandom_range(0, 2)));
        end

        // 6: RAM_WAIT=4 latency, then reset in the middle of WAIT
        access4(1'b1, 32'h0000_0020, 32'h1357_9BDF, acc, rc, wc, wn);
        chk("w4_ready_cycle", 32'(rc), 32'(acc + 4));
        chk("w4_we_cycle", 32'(wc), 32'(acc));
        chk("w4_we_count", 32'(wn), 32'd1);
        access4(1'b0, 32'h0000_0020, 32'h0, acc, rc, wc, wn);
        chk("r4_ready_cycle", 32'(rc), 32'(acc + 4));
        chk("r4_data_in", din4, 32'h1357_9BDF);
        chk("r4_we_count", 32'(wn), 32'd0);

        cpu4 = 1'b1; rd4 = 1'b1; wr4 = 1'b0; a4 = 32'h0000_0020;
        @(posedge clk); #1;
        cpu4 = 1'b0; rd4 = 1'b0;
        @(posedge clk); #1;
        chk("r4_in_wait", 32'(state4), 32'd1);
        reset4 = 1'b1;
        @(posedge clk); #1;
        chk("rst4_bus_state", 32'(state4), 32'd0);
        chk("rst4_data_in", din4, 32'd0);
        reset4 = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy4) pulses++;
        end
        chk("rst4_no_ready", 32'(pulses), 32'd0);
        $display("dut4 reset-in-wait sequence complete, ready pulses=%0d", pulses);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
